// File: rtl/seq_shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_add_multiplier_pkg
//  Purpose  : Shared definitions for the sequential shift-add multiplier.
//             - FSM state encodings (IDLE=0, RUN=1, DONE=2)
//             - Counter-width helper (ceil(log2(n)), minimum 1)
//  Revision : 1.0  initial release
// ============================================================================
package seq_shift_add_multiplier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shift_add_multiplier_shift_add_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_datapath
//  Purpose  : Multiplicand / multiplier / accumulator registers and the adder
//             of the shift-add multiplier. Operands arrive as unsigned
//             magnitudes; sign handling lives in the top level.
//  Ports    : clk          clock, rising edge
//             rst_n        asynchronous active-low reset
//             i_load       latch operands, clear accumulator
//             i_step       perform one shift-add iteration
//             i_mcand      multiplicand magnitude (WIDTH)
//             i_mplier     multiplier magnitude (WIDTH)
//             o_acc_next   accumulator value after the current iteration
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_datapath #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_step,
   input  logic [WIDTH-1:0]   i_mcand,
   input  logic [WIDTH-1:0]   i_mplier,
   output logic [2*WIDTH-1:0] o_acc_next
);

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_addend;

   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   // Exposed combinationally so the top can capture the final sum on the
   // same edge that performs the last iteration.
   assign o_acc_next = r_acc + w_addend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_load) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
         r_mplier <= i_mplier;
         r_acc    <= '0;
      end else if (i_step) begin
         r_acc    <= o_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_add_multiplier
//  Purpose  : WIDTH x WIDTH sequential shift-add multiplier, one partial
//             product per clock, start/done handshake.
//             IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//  Config   : SEQ_MULT_SIGNED_EN - when defined, a, b and p are two's
//             complement; otherwise unsigned only.
//  Ports    : clk     clock, rising edge
//             rst_n   asynchronous active-low reset
//             start   request, sampled only in IDLE
//             a, b    operands (WIDTH), latched on accept
//             busy    high in RUN and DONE
//             done    one-cycle pulse, p valid
//             p       product (2*WIDTH), held until next result
//  Revision : 1.0  initial release
// ============================================================================
module seq_shift_add_multiplier
   import seq_shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int                 c_CNT_W    = cnt_width(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_p;

   logic                 w_load;
   logic                 w_step;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_result;

   assign w_load = (r_state == ST_IDLE) && start;
   assign w_step = (r_state == ST_RUN);

`ifdef SEQ_MULT_SIGNED_EN
   logic r_sign;

   // |most-negative| fits as an unsigned WIDTH-bit magnitude (e.g. 4'b1000).
   assign w_a_mag  = a[WIDTH-1] ? -a : a;
   assign w_b_mag  = b[WIDTH-1] ? -b : b;
   assign w_result = r_sign ? -w_acc_next : w_acc_next;
`else
   assign w_a_mag  = a;
   assign w_b_mag  = b;
   assign w_result = w_acc_next;
`endif

   shift_add_datapath #(
      .WIDTH      (WIDTH)
   ) u_datapath (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_mcand    (w_a_mag),
      .i_mplier   (w_b_mag),
      .o_acc_next (w_acc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_p     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         r_sign  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                  r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + 1'b1;
               // Final iteration: capture the sum the datapath is producing now.
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= ST_DONE;
                  r_p     <= w_result;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shift_add_multiplier
//  Purpose  : Directed self-checking bench; a WIDTH=4 and a WIDTH=8 instance
//             run the same scenarios side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  p4;
   logic [15:0] p8;

   int n_checks = 0;
   int n_fail   = 0;
   int first_d  = 0;
   int second_d = 0;

   always #5 clk = ~clk;

   seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .p     (p4)
   );

   seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .p     (p8)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One operation on both instances. Edge 1 is the accepting edge; outputs
   // are sampled 1 time unit after each edge. Optionally re-pulses start with
   // a=b=1 while both instances are in RUN.
   task automatic run_op(input string tag,
                         input logic [3:0] va4, input logic [3:0] vb4,
                         input logic [7:0] va8, input logic [7:0] vb8,
                         input logic [7:0] e4,  input logic [15:0] e8,
                         input bit repulse);
      int lat4 = 0, lat8 = 0, nb4 = 0, nb8 = 0, nd4 = 0, nd8 = 0;
      logic [7:0]  got4 = '0;
      logic [15:0] got8 = '0;
      a4 = va4; b4 = vb4; a8 = va8; b8 = vb8;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         if (e > 1) begin
            @(posedge clk); #1;
         end
         if (busy4) nb4++;
         if (busy8) nb8++;
         if (done4) begin nd4++; lat4 = e; got4 = p4; end
         if (done8) begin nd8++; lat8 = e; got8 = p8; end
         if (repulse && e == 2) begin
            a4 = 4'd1; b4 = 4'd1; a8 = 8'd1; b8 = 8'd1; start = 1'b1;
         end
         if (repulse && e == 3) start = 1'b0;
         if (e > 1 && !busy4 && !busy8) break;
      end
      check_eq({tag, " p4"},      {24'd0, got4}, {24'd0, e4});
      check_eq({tag, " p8"},      {16'd0, got8}, {16'd0, e8});
      check_eq({tag, " lat4"},    lat4, 5);
      check_eq({tag, " lat8"},    lat8, 9);
      check_eq({tag, " busy4"},   nb4, 5);
      check_eq({tag, " busy8"},   nb8, 9);
      check_eq({tag, " ndone4"},  nd4, 1);
      check_eq({tag, " ndone8"},  nd8, 1);
      check_eq({tag, " hold p4"}, {24'd0, p4}, {24'd0, e4});
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      #1;
      check_eq("rst busy4", busy4, 0);
      check_eq("rst done4", done4, 0);
      check_eq("rst p4",    p4, 0);
      check_eq("rst p8",    p8, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

`ifdef SEQ_MULT_SIGNED_EN
      run_op("s m3x2",  4'hD, 4'h2, 8'hFD, 8'h02, 8'hFA, 16'hFFFA, 1'b0);
      run_op("s m8xm8", 4'h8, 4'h8, 8'h80, 8'h80, 8'h40, 16'h4000, 1'b0);
      run_op("s 3x2",   4'h3, 4'h2, 8'h03, 8'h02, 8'h06, 16'h0006, 1'b0);
`else
      run_op("2x2",     4'd2,  4'd2,  8'd2,   8'd2,   8'd4,   16'd4,    1'b0);
      run_op("3x2",     4'd3,  4'd2,  8'd3,   8'd2,   8'd6,   16'd6,    1'b0);
      run_op("max",     4'd15, 4'd15, 8'd255, 8'd255, 8'd225, 16'hFE01, 1'b0);
      run_op("0x13",    4'd0,  4'd13, 8'd0,   8'd13,  8'd0,   16'd0,    1'b0);
      run_op("13x0",    4'd13, 4'd0,  8'd13,  8'd0,   8'd0,   16'd0,    1'b0);
`endif
      run_op("repulse", 4'd3, 4'd5, 8'd3, 8'd5, 8'd15, 16'd15, 1'b1);

      // Asynchronous reset in the middle of RUN.
      a4 = 4'd6; b4 = 4'd7; a8 = 8'd6; b8 = 8'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst busy4", busy4, 0);
      check_eq("midrst done4", done4, 0);
      check_eq("midrst p4",    p4, 0);
      check_eq("midrst busy8", busy8, 0);
      check_eq("midrst p8",    p8, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check_eq("postrst no done8", done8, 0);
      end
      run_op("after rst", 4'd5, 4'd3, 8'd5, 8'd3, 8'd15, 16'd15, 1'b0);

      // start held high: back-to-back operations, one per WIDTH+2 cycles.
      a4 = 4'd2; b4 = 4'd3; a8 = 8'd2; b8 = 8'd3;
      start = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (done4) begin
            if (first_d == 0) first_d = e;
            else if (second_d == 0) second_d = e;
         end
      end
      start = 1'b0;
      check_eq("b2b period4", second_d - first_d, 6);
      check_eq("b2b p4", {24'd0, p4}, 32'd6);
      repeat (12) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
